// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime bit divisor, 5-9 data bits, optional
// even/odd parity and 1-2 stop bits, reporting framing/parity/break per word.
module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 EN,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 BREAK,
  output logic                 BUSY
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BRK    = 3'd5;

  logic                 sync1_q, sync2_q, prev_q;
  logic                 rx_s, fall, sample;
  logic [2:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, div_clamp;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 par_q, par_d, perr_q, perr_d;
  logic                 ferr_q, ferr_d, zero_q, zero_d;
  logic                 en_q, en_d, fe_q, fe_d, pe_q, pe_d, brk_q, brk_d;

  assign rx_s      = sync2_q;
  assign fall      = prev_q & ~sync2_q;
  assign div_clamp = (DIV < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : DIV;
  // The start bit is checked half a bit in; every later sample is one full bit on.
  assign sample    = (state_q == S_START) ? (cnt_q == (div_q >> 1)) : (cnt_q == div_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + DIV_WIDTH'(1);
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    data_d  = data_q;
    en_d    = 1'b0;
    fe_d    = fe_q;
    pe_d    = pe_q;
    brk_d   = brk_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          cnt_d   = DIV_WIDTH'(1);
          div_d   = div_clamp;
        end
      end
      S_START: begin
        if (sample) begin
          cnt_d = DIV_WIDTH'(1);
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            zero_d  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          cnt_d   = DIV_WIDTH'(1);
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rx_s;
          zero_d  = zero_q & ~rx_s;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          cnt_d   = DIV_WIDTH'(1);
          perr_d  = ((par_q ^ rx_s) != (PARITY == 2));
          zero_d  = zero_q & ~rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          cnt_d  = DIV_WIDTH'(1);
          ferr_d = ferr_q | ~rx_s;
          // Only the first stop sample takes part in break detection.
          if (bit_q == 4'd0) zero_d = zero_q & ~rx_s;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d   = '0;
            en_d    = 1'b1;
            data_d  = shift_q;
            fe_d    = ferr_d;
            pe_d    = perr_q;
            brk_d   = zero_d;
            state_d = zero_d ? S_BRK : S_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      data_q  <= data_d;
      en_q    <= en_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      brk_q   <= brk_d;
    end
  end

  assign DATA       = data_q;
  assign EN         = en_q;
  assign FRAME_ERR  = fe_q;
  assign PARITY_ERR = pe_q;
  assign BREAK      = brk_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8O2) driven with
// directed and random frames, compared against a frame-level model.
module tb_uart_rx_cfg;

  localparam int N = 3;

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       bk;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] rx;
  logic [15:0]  div [N];
  logic [7:0]   data0;
  logic [6:0]   data1;
  logic [7:0]   data2;
  logic [8:0]   dat [N];
  logic [N-1:0] en, fe, pe, bk, busy;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t act_q [N][$];
  ev_t exp_q [N][$];
  ev_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16)) u_8n1 (
    .CLK(clk), .RESET(rst), .DIV(div[0]), .RX(rx[0]), .DATA(data0), .EN(en[0]),
    .FRAME_ERR(fe[0]), .PARITY_ERR(pe[0]), .BREAK(bk[0]), .BUSY(busy[0]));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DIV_WIDTH(16)) u_7e1 (
    .CLK(clk), .RESET(rst), .DIV(div[1]), .RX(rx[1]), .DATA(data1), .EN(en[1]),
    .FRAME_ERR(fe[1]), .PARITY_ERR(pe[1]), .BREAK(bk[1]), .BUSY(busy[1]));
  uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_WIDTH(16)) u_8o2 (
    .CLK(clk), .RESET(rst), .DIV(div[2]), .RX(rx[2]), .DATA(data2), .EN(en[2]),
    .FRAME_ERR(fe[2]), .PARITY_ERR(pe[2]), .BREAK(bk[2]), .BUSY(busy[2]));

  assign dat[0] = {1'b0, data0};
  assign dat[1] = {2'b0, data1};
  assign dat[2] = {1'b0, data2};

  // Record every strobe with the cycle it was seen in.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (en[i] === 1'b1) begin
        mon_e.cyc  = cyc;
        mon_e.data = dat[i];
        mon_e.fe   = fe[i];
        mon_e.pe   = pe[i];
        mon_e.bk   = bk[i];
        act_q[i].push_back(mon_e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int db_of(input int i);
    return (i == 1) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int i);
    return i;
  endfunction
  function automatic int sb_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic check_reset(input int i);
    check($sformatf("rst%0d data", i), 32'(dat[i]), 0);
    check($sformatf("rst%0d en", i), 32'(en[i]), 0);
    check($sformatf("rst%0d fe", i), 32'(fe[i]), 0);
    check($sformatf("rst%0d pe", i), 32'(pe[i]), 0);
    check($sformatf("rst%0d bk", i), 32'(bk[i]), 0);
    check($sformatf("rst%0d busy", i), 32'(busy[i]), 0);
  endtask

  // Drive one frame at D = max(dv,4) clocks per bit and queue the expected word.
  // flip inverts the parity bit; stp holds the stop-bit levels (bit 0 first).
  task automatic send(input int i, input int dv, input logic [8:0] w, input logic flip,
                      input logic [1:0] stp, input int gap);
    int         d, db, pm, sb, n0;
    logic [8:0] wm;
    logic       pb;
    ev_t        e;
    d  = (dv < 4) ? 4 : dv;
    db = db_of(i);
    pm = pm_of(i);
    sb = sb_of(i);
    wm = w & 9'((1 << db) - 1);
    pb = (^wm) ^ (pm == 2) ^ flip;
    div[i] = 16'(dv);
    rx[i]  = 1'b0;
    n0     = cyc;
    repeat (d) tick();
    div[i] = 16'($urandom_range(0, 40));
    for (int k = 0; k < db; k++) begin
      rx[i] = wm[k];
      repeat (d) tick();
    end
    if (pm != 0) begin
      rx[i] = pb;
      repeat (d) tick();
    end
    for (int k = 0; k < sb; k++) begin
      rx[i] = stp[k];
      repeat (d) tick();
    end
    rx[i]  = 1'b1;
    e.cyc  = n0 + 2 + d / 2 + d * (db + ((pm != 0) ? 1 : 0) + sb) + 1;
    e.data = wm;
    e.pe   = (pm != 0) && flip;
    e.fe   = !stp[0] || (sb == 2 && !stp[1]);
    e.bk   = (wm == 0) && (pm == 0 || !pb) && !stp[0];
    exp_q[i].push_back(e);
    repeat (gap) tick();
  endtask

  task automatic compare(input int i, input string tag);
    ev_t a, x;
    check($sformatf("%s events", tag), act_q[i].size(), exp_q[i].size());
    while (act_q[i].size() > 0 && exp_q[i].size() > 0) begin
      a = act_q[i].pop_front();
      x = exp_q[i].pop_front();
      check($sformatf("%s cycle", tag), a.cyc, x.cyc);
      check($sformatf("%s data", tag), 32'(a.data), 32'(x.data));
      check($sformatf("%s frame_err", tag), 32'(a.fe), 32'(x.fe));
      check($sformatf("%s parity_err", tag), 32'(a.pe), 32'(x.pe));
      check($sformatf("%s break", tag), 32'(a.bk), 32'(x.bk));
    end
    act_q[i].delete();
    exp_q[i].delete();
  endtask

  initial begin
    int  n0;
    ev_t e;
    rst = 1'b1;
    rx  = '1;
    for (int i = 0; i < N; i++) div[i] = 16'd8;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < N; i++) check_reset(i);

    // Back-to-back 8N1 frames.
    send(0, 8, 9'h055, 1'b0, 2'b11, 0);
    send(0, 8, 9'h0A3, 1'b0, 2'b11, 16);
    compare(0, "b2b");

    // 7E1: correct parity, then corrupted parity.
    send(1, 10, 9'h041, 1'b0, 2'b11, 20);
    send(1, 10, 9'h041, 1'b1, 2'b11, 20);
    compare(1, "parity");

    // 8O2: second stop bit low, then a clean frame.
    send(2, 8, 9'h05A, 1'b0, 2'b01, 20);
    send(2, 8, 9'h0C3, 1'b0, 2'b11, 20);
    compare(2, "stop2");

    // Glitch shorter than half a bit is rejected.
    div[0] = 16'd16;
    rx[0]  = 1'b0;
    n0     = cyc;
    repeat (5) tick();
    rx[0] = 1'b1;
    wait_cyc(n0 + 2 + 3);
    check("glitch busy early", 32'(busy[0]), 1);
    wait_cyc(n0 + 2 + 8);
    check("glitch busy at check", 32'(busy[0]), 1);
    wait_cyc(n0 + 2 + 9);
    check("glitch busy after", 32'(busy[0]), 0);
    repeat (40) tick();
    compare(0, "glitch");

    // Line break: low for 30 bit times gives exactly one strobe.
    div[0] = 16'd8;
    rx[0]  = 1'b0;
    n0     = cyc;
    repeat (30 * 8) tick();
    e.cyc  = n0 + 2 + 4 + 8 * 9 + 1;
    e.data = '0;
    e.fe   = 1'b1;
    e.pe   = 1'b0;
    e.bk   = 1'b1;
    exp_q[0].push_back(e);
    check("break busy held", 32'(busy[0]), 1);
    rx[0] = 1'b1;
    repeat (20) tick();
    check("break busy released", 32'(busy[0]), 0);
    compare(0, "break");
    send(0, 8, 9'h096, 1'b0, 2'b11, 20);
    compare(0, "after break");

    // Reset during data bit 3 of 0x3C aborts the frame.
    div[0] = 16'd8;
    rx[0]  = 1'b0;
    repeat (8) tick();
    rx[0] = 1'b0;
    repeat (8) tick();
    rx[0] = 1'b0;
    repeat (8) tick();
    rx[0] = 1'b1;
    repeat (8) tick();
    rx[0] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst   = 1'b0;
    rx[0] = 1'b1;
    tick();
    check_reset(0);
    repeat (40) tick();
    compare(0, "abort");
    send(0, 8, 9'h03C, 1'b0, 2'b11, 20);
    compare(0, "post reset");

    // DIV below 4 is clamped to 4 clocks per bit.
    send(0, 2, 9'($urandom), 1'b0, 2'b11, 20);
    compare(0, "clamp");

    // Random frames on every configuration.
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 6; k++) begin
        int         dv, gp;
        logic [8:0] w;
        logic       fl;
        logic [1:0] st;
        dv = $urandom_range(4, 12);
        w  = 9'($urandom);
        fl = (pm_of(i) != 0) && ($urandom_range(0, 3) == 0);
        st = 2'b11;
        if ($urandom_range(0, 4) == 0) st[$urandom_range(0, sb_of(i) - 1)] = 1'b0;
        gp = (st == 2'b11 && $urandom_range(0, 1) == 1) ? 0 : 3 * dv;
        send(i, dv, w, fl, st, gp);
      end
      repeat (20) tick();
      compare(i, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
